// File: rtl/serial_slave_port.sv
// Slave endpoint of the serial system bus: shifts in address/R-W/write data,
// stores words in local memory and shifts read data back, optionally as a split read.
module serial_slave_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int SPLIT_EN   = 0,
  parameter int SPLIT_LAT  = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic B_SEL,
  input  logic B_UTIL,
  input  logic B_RW,
  input  logic B_BUS_OUT,
  output logic B_BUS_IN,
  output logic B_READY,
  output logic B_ACK,
  output logic B_SBSY,
  output logic B_SPLIT_REQ,
  input  logic B_SPL_RESUME
);

  localparam int CNT_W = $clog2((ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH) + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [7:0]       SPLIT_DONE = 8'(SPLIT_LAT);

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, WACK, RWAIT, RSPLIT, RDATA, RACK
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-2:0] wdata_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic [7:0]            split_cnt;
  logic                  rw_reg;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic bus_ok;
  logic addr_last;
  logic data_last;
  logic split_ready;
  logic mem_we;

  assign bus_ok      = B_SEL & B_UTIL;
  assign addr_last   = (bit_cnt == ADDR_LAST);
  assign data_last   = (bit_cnt == DATA_LAST);
  assign split_ready = (split_cnt == SPLIT_DONE);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    B_BUS_IN    = 1'b0;
    B_READY     = 1'b0;
    B_ACK       = 1'b0;
    B_SPLIT_REQ = 1'b0;
    B_SBSY      = (state != IDLE);
    mem_we      = 1'b0;
    case (state)
      IDLE: begin
        if (bus_ok) state_next = ADDR;
      end
      ADDR: begin
        if (!bus_ok) state_next = IDLE;
        else if (addr_last) begin
          if (rw_reg)             state_next = WDATA;
          else if (SPLIT_EN != 0) state_next = RSPLIT;
          else                    state_next = RWAIT;
        end
      end
      WDATA: begin
        if (!bus_ok) state_next = IDLE;
        else if (data_last) begin
          mem_we     = !RST;
          state_next = WACK;
        end
      end
      WACK: begin
        B_ACK      = 1'b1;
        state_next = IDLE;
      end
      RWAIT: begin
        state_next = RDATA;
      end
      RSPLIT: begin
        // Bus is released here; only a resume after the latency window matters
        B_SPLIT_REQ = (split_cnt == 8'd0);
        if (split_ready && B_SPL_RESUME && B_SEL) state_next = RWAIT;
      end
      RDATA: begin
        B_READY  = 1'b1;
        B_BUS_IN = rdata_reg[0];
        if (!bus_ok) state_next = IDLE;
        else if (data_last) state_next = RACK;
      end
      RACK: begin
        B_ACK      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Serial shift registers and bit/latency counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      bit_cnt   <= '0;
      split_cnt <= '0;
      rw_reg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus_ok) begin
            rw_reg   <= B_RW;
            addr_reg <= {B_BUS_OUT, addr_reg[ADDR_WIDTH-1:1]};
            bit_cnt  <= CNT_W'(1);
          end
        end
        ADDR: begin
          addr_reg  <= {B_BUS_OUT, addr_reg[ADDR_WIDTH-1:1]};
          bit_cnt   <= addr_last ? '0 : bit_cnt + 1'b1;
          split_cnt <= '0;
        end
        WDATA: begin
          wdata_reg <= {B_BUS_OUT, wdata_reg[DATA_WIDTH-2:1]};
          bit_cnt   <= bit_cnt + 1'b1;
        end
        RWAIT: begin
          rdata_reg <= mem[addr_reg];
          bit_cnt   <= '0;
        end
        RSPLIT: begin
          if (!split_ready) split_cnt <= split_cnt + 8'd1;
        end
        RDATA: begin
          rdata_reg <= rdata_reg >> 1;
          bit_cnt   <= bit_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Last data bit goes straight from the line into the word being stored
  always_ff @(posedge CLK) begin
    if (mem_we) mem[addr_reg] <= {B_BUS_OUT, wdata_reg};
  end

endmodule
